// File: rtl/poly_buzz_ctl.sv
// Multi-voice square-wave tone generator with per-voice amplitude/pan and a
// glitch-free retune port. Define POLY_BUZZ_SAT_EN to saturate the mix to 16 bits.
module poly_buzz_ctl #(
  parameter int unsigned VOICES = 2,
  parameter int unsigned DIV_W  = 22,
  parameter int unsigned VID_W  = 3
) (
  input  logic               clk_100mhz,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [VID_W-1:0]   cfg_voice,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [14:0]        cfg_amp,
  input  logic [1:0]         cfg_pan,
  output logic [VOICES-1:0]  voice_active,
  output logic [15:0]        audio_left,
  output logic [15:0]        audio_right
);

  localparam int unsigned AMP_W = 15;
  localparam int unsigned PAN_W = 2;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned SUM_W = OUT_W + VID_W;

  logic              pend_q, pend_d;
  logic [VID_W-1:0]  sv_q, sv_d;
  logic [DIV_W-1:0]  sdiv_q, sdiv_d;
  logic [AMP_W-1:0]  samp_q, samp_d;
  logic [PAN_W-1:0]  span_q, span_d;

  logic [DIV_W-1:0]  div_q [VOICES];
  logic [DIV_W-1:0]  div_d [VOICES];
  logic [DIV_W-1:0]  cnt_q [VOICES];
  logic [DIV_W-1:0]  cnt_d [VOICES];
  logic [AMP_W-1:0]  amp_q [VOICES];
  logic [AMP_W-1:0]  amp_d [VOICES];
  logic [PAN_W-1:0]  pan_q [VOICES];
  logic [PAN_W-1:0]  pan_d [VOICES];
  logic [VOICES-1:0] ph_q, ph_d;

  logic              rdy_q;
  logic [VOICES-1:0] act_q;
  logic [OUT_W-1:0]  left_q, right_q, left_d, right_d;

  logic signed [SUM_W-1:0] sum_l, sum_r, mag, contrib;

  assign cfg_ready    = rdy_q;
  assign voice_active = act_q;
  assign audio_left   = left_q;
  assign audio_right  = right_q;

  // Voice counters, edge-aligned apply of the pending slot, and slot capture.
  always_comb begin : next_state
    logic hit;
    logic wrap;
    hit    = 1'b0;
    wrap   = 1'b0;
    pend_d = pend_q;
    sv_d   = sv_q;
    sdiv_d = sdiv_q;
    samp_d = samp_q;
    span_d = span_q;
    ph_d   = ph_q;
    for (int unsigned v = 0; v < VOICES; v++) begin
      div_d[v] = div_q[v];
      cnt_d[v] = cnt_q[v];
      amp_d[v] = amp_q[v];
      pan_d[v] = pan_q[v];
    end
    for (int unsigned v = 0; v < VOICES; v++) begin
      hit  = pend_q && (sv_q == VID_W'(v));
      wrap = (div_q[v] != '0) && (cnt_q[v] == div_q[v] - DIV_W'(1));
      if (div_q[v] == '0) begin
        cnt_d[v] = '0;
        ph_d[v]  = 1'b0;
      end else if (wrap) begin
        cnt_d[v] = '0;
        ph_d[v]  = ~ph_q[v];
      end else begin
        cnt_d[v] = cnt_q[v] + DIV_W'(1);
      end
      // A muted target loads at once; a running one only on its own wrap.
      if (hit && ((div_q[v] == '0) || wrap)) begin
        div_d[v] = sdiv_q;
        amp_d[v] = samp_q;
        pan_d[v] = span_q;
        pend_d   = 1'b0;
        if ((div_q[v] == '0) || (sdiv_q == '0)) ph_d[v] = 1'b0;
      end
    end
    if (rdy_q && cfg_valid && (32'(cfg_voice) < VOICES)) begin
      pend_d = 1'b1;
      sv_d   = cfg_voice;
      sdiv_d = cfg_div;
      samp_d = cfg_amp;
      span_d = cfg_pan;
    end
  end

  // Signed per-channel mix of the current voice waveforms.
  always_comb begin : mix
    sum_l   = '0;
    sum_r   = '0;
    mag     = '0;
    contrib = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      mag     = SUM_W'(amp_q[v]);
      contrib = ph_q[v] ? mag : -mag;
      if (div_q[v] == '0) contrib = '0;
      if (pan_q[v][0]) sum_l = sum_l + contrib;
      if (pan_q[v][1]) sum_r = sum_r + contrib;
    end
  end

`ifdef POLY_BUZZ_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32'sd32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32'sd32768);

  always_comb begin : reduce
    left_d  = sum_l[OUT_W-1:0];
    right_d = sum_r[OUT_W-1:0];
    if (sum_l > SAT_MAX)      left_d = 16'h7FFF;
    else if (sum_l < SAT_MIN) left_d = 16'h8000;
    if (sum_r > SAT_MAX)      right_d = 16'h7FFF;
    else if (sum_r < SAT_MIN) right_d = 16'h8000;
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^{sum_l[SUM_W-1:OUT_W], sum_r[SUM_W-1:OUT_W]};

  always_comb begin : reduce
    left_d  = sum_l[OUT_W-1:0];
    right_d = sum_r[OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk_100mhz or negedge rst_n) begin : state_regs
    if (!rst_n) begin
      pend_q  <= 1'b0;
      sv_q    <= '0;
      sdiv_q  <= '0;
      samp_q  <= '0;
      span_q  <= '0;
      ph_q    <= '0;
      rdy_q   <= 1'b1;
      act_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        div_q[v] <= '0;
        cnt_q[v] <= '0;
        amp_q[v] <= '0;
        pan_q[v] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      sv_q    <= sv_d;
      sdiv_q  <= sdiv_d;
      samp_q  <= samp_d;
      span_q  <= span_d;
      ph_q    <= ph_d;
      rdy_q   <= !pend_d;
      left_q  <= left_d;
      right_q <= right_d;
      for (int unsigned v = 0; v < VOICES; v++) begin
        div_q[v] <= div_d[v];
        cnt_q[v] <= cnt_d[v];
        amp_q[v] <= amp_d[v];
        pan_q[v] <= pan_d[v];
        act_q[v] <= (div_d[v] != '0);
      end
    end
  end

endmodule

// File: tb/tb_poly_buzz_ctl.sv
// Scoreboard bench for poly_buzz_ctl: expected per-cycle outputs are queued
// at each transfer and compared one entry per clock.
module tb_poly_buzz_ctl;

  localparam int unsigned VOICES = 2;
  localparam int unsigned DIV_W  = 22;
  localparam int unsigned VID_W  = 3;

`ifdef POLY_BUZZ_SAT_EN
  localparam logic [15:0] LOUD_POS = 16'h7FFF;
  localparam logic [15:0] LOUD_NEG = 16'h8000;
`else
  localparam logic [15:0] LOUD_POS = 16'hE000;
  localparam logic [15:0] LOUD_NEG = 16'h2000;
`endif

  logic              clk_100mhz = 1'b0;
  logic              rst_n      = 1'b0;
  logic              cfg_valid  = 1'b0;
  logic              cfg_ready;
  logic [VID_W-1:0]  cfg_voice  = '0;
  logic [DIV_W-1:0]  cfg_div    = '0;
  logic [14:0]       cfg_amp    = '0;
  logic [1:0]        cfg_pan    = '0;
  logic [VOICES-1:0] voice_active;
  logic [15:0]       audio_left;
  logic [15:0]       audio_right;

  always #5 clk_100mhz = ~clk_100mhz;

  poly_buzz_ctl #(.VOICES(VOICES), .DIV_W(DIV_W), .VID_W(VID_W)) dut (
    .clk_100mhz   (clk_100mhz),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_voice    (cfg_voice),
    .cfg_div      (cfg_div),
    .cfg_amp      (cfg_amp),
    .cfg_pan      (cfg_pan),
    .voice_active (voice_active),
    .audio_left   (audio_left),
    .audio_right  (audio_right)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        rdy;
    logic [1:0]  act;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r,
                      input logic rdy, input logic [1:0] act, input int n);
    exp_t e;
    e.l = l; e.r = r; e.rdy = rdy; e.act = act;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      check({tag, "_left"},  32'(audio_left),   32'(e.l));
      check({tag, "_right"}, 32'(audio_right),  32'(e.r));
      check({tag, "_ready"}, 32'(cfg_ready),    32'(e.rdy));
      check({tag, "_active"}, 32'(voice_active), 32'(e.act));
    end
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Returns just after the accepting edge.
  task automatic cfg_send(input logic [VID_W-1:0] voice, input logic [DIV_W-1:0] div,
                          input logic [14:0] amp, input logic [1:0] pan);
    int n;
    n = 0;
    while (!cfg_ready && n < 300) begin
      tick();
      n++;
    end
    check("send_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_voice = voice;
    cfg_div   = div;
    cfg_amp   = amp;
    cfg_pan   = pan;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    // 1: reset values and out-of-range voice discard
    do_reset();
    check("t1_rst_left",   32'(audio_left),   32'd0);
    check("t1_rst_right",  32'(audio_right),  32'd0);
    check("t1_rst_ready",  32'(cfg_ready),    32'd1);
    check("t1_rst_active", 32'(voice_active), 32'd0);
    cfg_send(3'd5, 22'd4, 15'h1000, 2'd3);
    check("t1_bad_voice_ready", 32'(cfg_ready), 32'd1);
    push(16'h0000, 16'h0000, 1'b1, 2'b00, 3);
    drain("t1");

    // 2: single voice, div 4, both channels
    do_reset();
    cfg_send(3'd0, 22'd4, 15'h1000, 2'd3);
    check("t2_acc_ready", 32'(cfg_ready), 32'd0);
    push(16'h0000, 16'h0000, 1'b1, 2'b01, 1);
    for (int i = 0; i < 3; i++) begin
      push(16'hF000, 16'hF000, 1'b1, 2'b01, 4);
      push(16'h1000, 16'h1000, 1'b1, 2'b01, 4);
    end
    drain("t2");

    // 3: two phase-aligned loud voices; voice0 is aligned via a div=2 lead-in
    do_reset();
    cfg_send(3'd1, 22'd8, 15'h7000, 2'd3);
    tick();
    cfg_send(3'd0, 22'd2, 15'h7000, 2'd3);
    repeat (4) tick();
    cfg_send(3'd0, 22'd8, 15'h7000, 2'd3);
    check("t3_acc_ready", 32'(cfg_ready), 32'd0);
    repeat (2) tick();
    check("t3_apply_ready",  32'(cfg_ready),    32'd1);
    check("t3_apply_active", 32'(voice_active), 32'd3);
    for (int i = 0; i < 2; i++) begin
      push(LOUD_POS, LOUD_POS, 1'b1, 2'b11, 8);
      push(LOUD_NEG, LOUD_NEG, 1'b1, 2'b11, 8);
    end
    drain("t3");

    // 4: retune a running voice mid half-period
    do_reset();
    cfg_send(3'd0, 22'd100, 15'h0100, 2'd1);
    repeat (20) tick();
    cfg_send(3'd0, 22'd10, 15'h0100, 2'd1);
    check("t4_acc_ready", 32'(cfg_ready), 32'd0);
    push(16'hFF00, 16'h0000, 1'b0, 2'b01, 79);
    push(16'hFF00, 16'h0000, 1'b1, 2'b01, 1);
    push(16'h0100, 16'h0000, 1'b1, 2'b01, 10);
    push(16'hFF00, 16'h0000, 1'b1, 2'b01, 10);
    push(16'h0100, 16'h0000, 1'b1, 2'b01, 10);
    drain("t4");

    // 5: left-only voice, then mute at the next wrap
    do_reset();
    cfg_send(3'd0, 22'd6, 15'h0800, 2'd1);
    push(16'h0000, 16'h0000, 1'b1, 2'b01, 1);
    push(16'hF800, 16'h0000, 1'b1, 2'b01, 6);
    push(16'h0800, 16'h0000, 1'b1, 2'b01, 6);
    drain("t5a");
    cfg_send(3'd0, 22'd0, 15'h0800, 2'd1);
    check("t5_acc_ready", 32'(cfg_ready), 32'd0);
    push(16'hF800, 16'h0000, 1'b0, 2'b01, 4);
    push(16'hF800, 16'h0000, 1'b1, 2'b00, 1);
    push(16'h0000, 16'h0000, 1'b1, 2'b00, 6);
    drain("t5b");

    // 6: asynchronous reset with a request pending on a running voice
    do_reset();
    cfg_send(3'd0, 22'd5, 15'h0400, 2'd3);
    repeat (3) tick();
    cfg_send(3'd0, 22'd3, 15'h0100, 2'd3);
    check("t6_pend_ready", 32'(cfg_ready),  32'd0);
    check("t6_pre_left",   32'(audio_left), 32'h0000FC00);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_left",   32'(audio_left),   32'd0);
    check("t6_async_right",  32'(audio_right),  32'd0);
    check("t6_async_ready",  32'(cfg_ready),    32'd1);
    check("t6_async_active", 32'(voice_active), 32'd0);
    #2 rst_n = 1'b1;
    push(16'h0000, 16'h0000, 1'b1, 2'b00, 10);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
